// File: rtl/uart_cmd_ctrl.sv
// Frame parser between the UART RX/TX FIFOs and a simple 8-bit register bus.
// Frames: 0x55, CMD, ADDR, [DATA], CHK; answers are queued into the TX FIFO.
module uart_cmd_ctrl #(
    parameter int unsigned TIMEOUT_CYC = 1250000,
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       enable,
    input  logic       rx_empty,
    output logic       rx_rd_en,
    input  logic [7:0] rx_rdata,
    input  logic       tx_full,
    output logic       tx_wr_en,
    output logic [7:0] tx_wdata,
    output logic       reg_wr_en,
    output logic       reg_rd_en,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    input  logic [7:0] reg_rdata,
    input  logic       reg_rd_ack,
    output logic       busy,
    output logic [7:0] err_cnt
);

    typedef enum logic [3:0] {
        StIdle, StGetCmd, StGetAddr, StGetData, StGetChk,
        StExec, StWaitAck, StResp, StRespErr
    } state_e;

    state_e      state_q, state_d;
    logic        fetch_q;
    logic        is_wr_q, is_wr_d;
    logic [7:0]  sum_q, sum_d;
    logic [7:0]  addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [31:0] resp_q, resp_d;
    logic [2:0]  resp_cnt_q, resp_cnt_d;
    logic [31:0] tmr_q, tmr_d;
    logic [31:0] ack_tmr_q, ack_tmr_d;
    logic [7:0]  err_q;
    logic        err_inc;
    logic        in_get;
    logic [7:0]  rd_sum;

    // fetch_q marks the cycle in which rx_rdata carries the fetched byte
    always_comb begin
        in_get   = (state_q == StGetCmd) || (state_q == StGetAddr) ||
                   (state_q == StGetData) || (state_q == StGetChk);
        rx_rd_en = !rx_empty && !fetch_q && (in_get || (state_q == StIdle && enable));
        tx_wr_en = ((state_q == StResp) || (state_q == StRespErr)) && !tx_full;
        tx_wdata = tx_wr_en ? resp_q[31:24] : 8'h00;
        reg_wr_en = (state_q == StExec) && is_wr_q;
        reg_rd_en = (state_q == StExec) && !is_wr_q;
        reg_addr  = addr_q;
        reg_wdata = wdata_q;
        busy      = (state_q != StIdle);
        err_cnt   = err_q;
        rd_sum    = addr_q + reg_rdata;
    end

    always_comb begin
        state_d    = state_q;
        is_wr_d    = is_wr_q;
        sum_d      = sum_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        resp_d     = resp_q;
        resp_cnt_d = resp_cnt_q;
        tmr_d      = '0;
        ack_tmr_d  = '0;
        err_inc    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (fetch_q && rx_rdata == 8'h55) state_d = StGetCmd;
            end
            StGetCmd: begin
                if (fetch_q) begin
                    if (rx_rdata == 8'h01 || rx_rdata == 8'h02) begin
                        is_wr_d = (rx_rdata == 8'h01);
                        sum_d   = rx_rdata;
                        state_d = StGetAddr;
                    end else begin
                        state_d = StRespErr;
                    end
                end
            end
            StGetAddr: begin
                if (fetch_q) begin
                    addr_d  = rx_rdata;
                    sum_d   = sum_q + rx_rdata;
                    state_d = is_wr_q ? StGetData : StGetChk;
                end
            end
            StGetData: begin
                if (fetch_q) begin
                    wdata_d = rx_rdata;
                    sum_d   = sum_q + rx_rdata;
                    state_d = StGetChk;
                end
            end
            StGetChk: begin
                if (fetch_q) state_d = (rx_rdata == sum_q) ? StExec : StRespErr;
            end
            StExec: begin
                if (is_wr_q) begin
                    resp_d     = {8'hAA, 8'h01, 16'h0000};
                    resp_cnt_d = 3'd2;
                    state_d    = StResp;
                end else begin
                    state_d = StWaitAck;
                end
            end
            StWaitAck: begin
                if (reg_rd_ack) begin
                    resp_d     = {8'hAA, addr_q, reg_rdata, rd_sum};
                    resp_cnt_d = 3'd4;
                    state_d    = StResp;
                end else if (ack_tmr_q >= ACK_TIMEOUT - 1) begin
                    state_d = StRespErr;
                end else begin
                    ack_tmr_d = ack_tmr_q + 32'd1;
                end
            end
            StResp, StRespErr: begin
                if (!tx_full) begin
                    resp_d     = {resp_q[23:0], 8'h00};
                    resp_cnt_d = resp_cnt_q - 3'd1;
                    if (resp_cnt_q == 3'd1) state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Inter-byte timeout; a fetch issued this cycle takes precedence
        if (in_get && !fetch_q) begin
            if (!rx_rd_en && tmr_q >= TIMEOUT_CYC - 1) begin
                state_d = StIdle;
                err_inc = 1'b1;
            end else begin
                tmr_d = tmr_q + 32'd1;
            end
        end

        if (state_d == StRespErr && state_q != StRespErr) begin
            resp_d     = {8'hEE, 24'h000000};
            resp_cnt_d = 3'd1;
            err_inc    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= StIdle;
            fetch_q    <= 1'b0;
            is_wr_q    <= 1'b0;
            sum_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            resp_q     <= '0;
            resp_cnt_q <= '0;
            tmr_q      <= '0;
            ack_tmr_q  <= '0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            fetch_q    <= rx_rd_en;
            is_wr_q    <= is_wr_d;
            sum_q      <= sum_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            resp_q     <= resp_d;
            resp_cnt_q <= resp_cnt_d;
            tmr_q      <= tmr_d;
            ack_tmr_q  <= ack_tmr_d;
            if (err_inc && err_q != 8'hFF) err_q <= err_q + 8'd1;
        end
    end

endmodule

// File: doc/uart_cmd_ctrl.md
Name: uart_cmd_ctrl

Overview:
Command controller placed behind the FIFO-buffered UART transceiver. It pulls bytes from the UART RX FIFO and parses fixed-format command frames. Valid frames become single-cycle register-bus writes or reads. Responses go into the UART TX FIFO, giving host-side register access over the serial link.

Parameters:
TIMEOUT_CYC, 1250000, max clk cycles between bytes inside a frame before the parser aborts (10 ms at 125 MHz)
ACK_TIMEOUT, 255, max clk cycles to wait for reg_rd_ack after reg_rd_en

Ports:
clk  in  1  system clock; same clock as the UART core's FIFO sides
nrst  in  1  reset, asynchronous, active-low
enable  in  1  1 = process frames; 0 = finish current frame/response, then hold in IDLE
rx_empty  in  1  RX FIFO empty
rx_rd_en  out  1  RX FIFO read pulse
rx_rdata  in  8  RX FIFO data, valid the cycle after rx_rd_en
tx_full  in  1  TX FIFO almost-full
tx_wr_en  out  1  TX FIFO write pulse
tx_wdata  out  8  TX FIFO write data
reg_wr_en  out  1  register write strobe, 1 cycle
reg_rd_en  out  1  register read strobe, 1 cycle
reg_addr  out  8  register address
reg_wdata  out  8  register write data
reg_rdata  in  8  register read data, valid with reg_rd_ack
reg_rd_ack  in  1  read data valid
busy  out  1  high in any state other than IDLE
err_cnt  out  8  saturating count of rejected or aborted frames

Behaviour:
- Reset: all outputs 0. State = IDLE. Timers cleared.
- Frame format: 0x55, CMD, ADDR, [DATA if CMD=0x01], CHK.
  - CHK = (CMD+ADDR+DATA) mod 256 for a write.
  - CHK = (CMD+ADDR) mod 256 for a read.
- Byte fetch:
  - rx_rd_en pulses for 1 cycle only when rx_empty=0 and no fetch is in flight.
  - The byte is sampled from rx_rdata exactly 1 cycle later.
  - Max one fetch per 2 cycles.
- States:
  - IDLE: if enable, fetch a byte. 0x55 -> GET_CMD. Any other byte is discarded, stay in IDLE, err_cnt unchanged.
  - GET_CMD: 0x01 or 0x02 -> GET_ADDR. Any other value -> RESP_ERR.
  - GET_ADDR: latch reg_addr. Write -> GET_DATA. Read -> GET_CHK.
  - GET_DATA: latch reg_wdata -> GET_CHK.
  - GET_CHK: match -> EXEC. Mismatch -> RESP_ERR.
  - EXEC, write: reg_wr_en=1 for 1 cycle, then RESP with bytes {0xAA, 0x01}.
  - EXEC, read: reg_rd_en=1 for 1 cycle, then WAIT_ACK.
  - WAIT_ACK: on reg_rd_ack, latch reg_rdata, then RESP with bytes {0xAA, ADDR, RDATA, (ADDR+RDATA) mod 256}. If ACK_TIMEOUT cycles pass without ack -> RESP_ERR.
  - RESP / RESP_ERR: emit bytes in order. RESP_ERR emits the single byte 0xEE.
  - After the last byte -> IDLE. On every RESP_ERR entry, err_cnt increments, saturating at 0xFF.
- TX rule:
  - tx_wr_en is asserted only in a cycle where tx_full=0.
  - tx_wdata is stable in that cycle.
  - While tx_full=1, the current byte is held and no byte is skipped or duplicated.
  - Back-to-back writes are allowed while tx_full stays 0.
- Inter-byte timeout:
  - Counter runs in GET_CMD..GET_CHK while waiting for data.
  - It resets on each fetched byte.
  - On reaching TIMEOUT_CYC: return to IDLE, err_cnt+1, no TX response, no register strobe.
- reg_wr_en and reg_rd_en are never asserted together. Each asserts at most once per frame.
- reg_addr and reg_wdata hold their values until the next frame latches new ones.
- A reg_rd_ack outside WAIT_ACK is ignored.
- enable deasserted mid-frame: the frame completes, including its response. The next 0x55 is not fetched until enable=1.
- nrst asserted mid-operation: immediate return to reset state. Any partial TX response is abandoned.

Test Plan:
- Write: RX 55 01 10 A5 B6 -> one reg_wr_en with reg_addr=0x10, reg_wdata=0xA5; TX AA 01; err_cnt=0.
- Read: RX 55 02 20 22, ack 3 cycles after reg_rd_en with reg_rdata=0x3C -> TX AA 20 3C 5C.
- Bad checksum 55 01 10 A5 00 -> no reg_wr_en; TX EE; err_cnt=1. Bad command 55 07 -> TX EE; err_cnt=2.
- Resync: RX 00 FF 13 55 01 10 A5 B6 -> leading bytes dropped silently; one write executed; TX AA 01.
- Timeout: RX 55 01 then silence > TIMEOUT_CYC (set to 100) -> busy falls, err_cnt+1, no TX; a following valid frame executes normally.
- Backpressure/ack timeout: read frame with tx_full held 1 for 50 cycles -> TX AA 20 3C 5C intact and in order after release. No reg_rd_ack -> TX EE after ACK_TIMEOUT cycles.
